// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and status signals around the fetch/data memory port arbiter.
// The arbiter connects through master; requesters and the memory connect through slave.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;

  logic              owner;
  logic [1:0]        state_out;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata, mem_addr, mem_wdata, mem_wr,
           owner, state_out
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata, mem_addr, mem_wdata, mem_wr,
           owner, state_out
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store:
// round-robin grant, fixed read latency, one-cycle ack per completed access.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                clock_i,
  input  logic                reset_i,
  mem_port_arbiter_if.master  bus
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_owner_q, last_owner_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_wr_q, mem_wr_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              grant_dm;

  // State and datapath registers; reset abandons any in-flight access
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      last_owner_q <= 1'b1;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wr_q     <= 1'b0;
      if_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wr_q     <= mem_wr_d;
      if_ack_q     <= if_ack_d;
      dm_ack_q     <= dm_ack_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  // Next state; ack and mem_wr are computed one cycle ahead so they leave as flops
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wr_d     = 1'b0;
    if_ack_d     = 1'b0;
    dm_ack_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    grant_dm     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          // On a tie the requester that was not served last wins
          grant_dm   = bus.dm_req && (!bus.if_req || !last_owner_q);
          owner_d    = grant_dm;
          we_d       = grant_dm && bus.dm_we;
          mem_addr_d = grant_dm ? bus.dm_addr : bus.if_addr;
          if (grant_dm) begin
            mem_wdata_d = bus.dm_wdata;
          end
          mem_wr_d = grant_dm && bus.dm_we;
          cnt_d    = CNT_W'(WAIT_CYCLES - 1);
          state_d  = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (we_q || (cnt_q == '0)) begin
          state_d  = S_RESP;
          if_ack_d = !owner_q;
          dm_ack_d = owner_q;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = S_RESP;
          if_ack_d = !owner_q;
          dm_ack_d = owner_q;
        end
      end

      S_RESP: begin
        last_owner_d = owner_q;
        if (!we_q) begin
          if (owner_q) begin
            dm_rdata_d = bus.mem_rdata;
          end else begin
            if_rdata_d = bus.mem_rdata;
          end
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Read data passes straight through during the response cycle, then holds
  assign bus.if_rdata  = if_rdata_d;
  assign bus.dm_rdata  = dm_rdata_d;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.owner     = owner_q;
  assign bus.state_out = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// request mixes checked against a transaction-level model of grant order, latency and data.
module tb_mem_port_arbiter;

  localparam int unsigned WC = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(WC)) dut (
    .clock_i(clk), .reset_i(reset), .bus(bus.master));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
    .clock_i(clk), .reset_i(reset), .bus(bus1.master));

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C22_0004;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Memory environment: data is only visible WC cycles after the address is presented
  bit          env_v [256];
  logic [31:0] env_d [256];
  int          age  = 0;
  int          age1 = 0;

  always @(posedge clk) begin
    if (bus.mem_wr) begin
      env_v[bus.mem_addr[9:2]] <= 1'b1;
      env_d[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
    if (bus.state_out == 2'd1) age <= 1;
    else if (age < 100) age <= age + 1;
    if (bus1.state_out == 2'd1) age1 <= 1;
    else if (age1 < 100) age1 <= age1 + 1;
  end

  assign bus.mem_rdata = (bus.state_out != 2'd1 && age >= int'(WC)) ?
      (env_v[bus.mem_addr[9:2]] ? env_d[bus.mem_addr[9:2]] : init_word(bus.mem_addr)) :
      32'hBAD0_BAD0;
  assign bus1.mem_rdata = (bus1.state_out != 2'd1 && age1 >= 1) ?
      init_word(bus1.mem_addr) : 32'hBAD0_BAD0;

  // Reference model state
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] m_rdata [2];
  bit          m_last;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return init_word(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_last     = 1'b1;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
  endtask

  // Walks pre idle cycles plus one transaction, checking every cycle against the model
  task automatic expect_ack(input int pre, input bit who, input bit wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input bit perturb, input string tag);
    int lat;
    logic [31:0] exp_rd;
    logic [1:0]  exp_st;
    lat    = wr ? 2 : int'(WC) + 1;
    exp_rd = wr ? m_rdata[who] : model_rd(addr);
    for (int k = 1; k <= pre + lat; k++) begin
      int j;
      step();
      j = k - pre;
      if (j <= 0) begin
        chk({tag, ".idle_state"}, 32'(bus.state_out), 32'd0);
        chk({tag, ".idle_ack"}, 32'({bus.if_ack, bus.dm_ack}), 32'd0);
        chk({tag, ".idle_wr"}, 32'(bus.mem_wr), 32'd0);
      end else begin
        exp_st = (j == 1) ? 2'd1 : (j == lat) ? 2'd3 : 2'd2;
        chk({tag, ".state"}, 32'(bus.state_out), 32'(exp_st));
        chk({tag, ".owner"}, 32'(bus.owner), 32'(who));
        chk({tag, ".mem_addr"}, bus.mem_addr, addr);
        chk({tag, ".mem_wr"}, 32'(bus.mem_wr), 32'(j == 1 && wr));
        if (j == 1 && wr) chk({tag, ".mem_wdata"}, bus.mem_wdata, wdata);
        chk({tag, ".if_ack"}, 32'(bus.if_ack), 32'(j == lat && !who));
        chk({tag, ".dm_ack"}, 32'(bus.dm_ack), 32'(j == lat && who));
        if (j == lat) begin
          chk({tag, ".if_rdata"}, bus.if_rdata, who ? m_rdata[0] : exp_rd);
          chk({tag, ".dm_rdata"}, bus.dm_rdata, who ? exp_rd : m_rdata[1]);
        end
        if (perturb && j == 1) begin
          bus.if_addr = 32'h80;
          bus.if_req  = 1'b0;
        end
      end
    end
    if (wr) model_mem[addr] = wdata;
    else    m_rdata[who]    = exp_rd;
    m_last = who;
    if (who) bus.dm_req = 1'b0;
    else     bus.if_req = 1'b0;
  endtask

  initial begin
    int gap, want;
    bit wi, wd, dwe, winner, in_resp;
    logic [31:0] ia, da, dwd;

    bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0;
    bus.dm_addr = '0; bus.dm_wdata = '0;
    bus1.if_req = 0; bus1.if_addr = '0; bus1.dm_req = 0; bus1.dm_we = 0;
    bus1.dm_addr = '0; bus1.dm_wdata = '0;
    model_reset();

    // Reset values
    step(); step();
    chk("rst.state", 32'(bus.state_out), 32'd0);
    chk("rst.ack", 32'({bus.if_ack, bus.dm_ack}), 32'd0);
    chk("rst.mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("rst.mem_addr", bus.mem_addr, 32'd0);
    chk("rst.mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst.if_rdata", bus.if_rdata, 32'd0);
    chk("rst.dm_rdata", bus.dm_rdata, 32'd0);
    chk("rst.owner", 32'(bus.owner), 32'd0);
    chk("rst1.state", 32'(bus1.state_out), 32'd0);
    reset = 1'b0;

    // Single fetch, then rdata holds through idle
    bus.if_req = 1; bus.if_addr = 32'h40;
    expect_ack(0, 1'b0, 1'b0, 32'h40, '0, 1'b0, "fetch");
    chk("fetch.rdata_ack", bus.if_rdata, 32'h8C22_0004);
    step();
    chk("fetch.rdata_hold", bus.if_rdata, 32'h8C22_0004);
    chk("fetch.idle", 32'(bus.state_out), 32'd0);

    // Store then load back the same word
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h100; bus.dm_wdata = 32'hDEAD_BEEF;
    expect_ack(0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0, "store");
    bus.dm_req = 1; bus.dm_we = 0;
    expect_ack(1, 1'b1, 1'b0, 32'h100, '0, 1'b0, "load");
    chk("load.value", bus.dm_rdata, 32'hDEAD_BEEF);

    // Simultaneous requests right after reset, then alternation
    reset = 1'b1; step(); reset = 1'b0; model_reset();
    bus.if_req = 1; bus.if_addr = 32'h40;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h100;
    expect_ack(0, 1'b0, 1'b0, 32'h40, '0, 1'b0, "tie1_if");
    expect_ack(1, 1'b1, 1'b0, 32'h100, '0, 1'b0, "tie1_dm");
    bus.if_req = 1; bus.dm_req = 1;
    expect_ack(1, 1'b0, 1'b0, 32'h40, '0, 1'b0, "tie2_if");
    expect_ack(1, 1'b1, 1'b0, 32'h100, '0, 1'b0, "tie2_dm");

    // Reset during WAIT abandons the read
    step();
    bus.if_req = 1; bus.if_addr = 32'h44;
    step(); chk("rstw.c1", 32'(bus.state_out), 32'd1);
    step(); chk("rstw.c2", 32'(bus.state_out), 32'd2);
    reset = 1'b1; bus.if_req = 0;
    step();
    chk("rstw.state", 32'(bus.state_out), 32'd0);
    chk("rstw.ack", 32'({bus.if_ack, bus.dm_ack}), 32'd0);
    chk("rstw.mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("rstw.mem_addr", bus.mem_addr, 32'd0);
    chk("rstw.if_rdata", bus.if_rdata, 32'd0);
    chk("rstw.dm_rdata", bus.dm_rdata, 32'd0);
    reset = 1'b0; model_reset();
    bus.if_req = 1; bus.if_addr = 32'h40;
    expect_ack(0, 1'b0, 1'b0, 32'h40, '0, 1'b0, "post_rst");

    // Requester changes address and drops req mid-transaction
    bus.if_req = 1; bus.if_addr = 32'h40;
    expect_ack(1, 1'b0, 1'b0, 32'h40, '0, 1'b1, "perturb");

    // Randomized request mixes
    in_resp = 1'b1;
    for (int r = 0; r < 40; r++) begin
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        step();
        chk("rnd.gap_state", 32'(bus.state_out), 32'd0);
      end
      want = int'($urandom_range(1, 3));
      wi  = want[0];
      wd  = want[1];
      ia  = 32'h100 + 32'($urandom_range(0, 15)) * 4;
      da  = 32'h100 + 32'($urandom_range(0, 15)) * 4;
      dwe = 1'($urandom_range(0, 1));
      dwd = $urandom;
      bus.if_req = wi; bus.if_addr = ia;
      bus.dm_req = wd; bus.dm_we = dwe; bus.dm_addr = da; bus.dm_wdata = dwd;
      winner = (wi && wd) ? !m_last : wd;
      if (!winner) begin
        expect_ack((gap == 0 && in_resp) ? 1 : 0, 1'b0, 1'b0, ia, '0, 1'b0, "rnd_if");
        if (wd) expect_ack(1, 1'b1, dwe, da, dwd, 1'b0, "rnd_dm2");
      end else begin
        expect_ack((gap == 0 && in_resp) ? 1 : 0, 1'b1, dwe, da, dwd, 1'b0, "rnd_dm");
        if (wi) expect_ack(1, 1'b0, 1'b0, ia, '0, 1'b0, "rnd_if2");
      end
      in_resp = 1'b1;
    end

    // Single-cycle latency instance never visits WAIT
    bus1.if_req = 1; bus1.if_addr = 32'h40;
    step();
    chk("w1.c1", 32'(bus1.state_out), 32'd1);
    step();
    chk("w1.c2", 32'(bus1.state_out), 32'd3);
    chk("w1.ack", 32'(bus1.if_ack), 32'd1);
    chk("w1.rdata", bus1.if_rdata, 32'h8C22_0004);
    for (int c = 0; c < 16; c++) begin
      bus1.if_addr = 32'h100 + 32'($urandom_range(0, 15)) * 4;
      step();
      chk("w1.no_wait", 32'(bus1.state_out == 2'd2), 32'd0);
    end
    bus1.if_req = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
